// File: rtl/imem_pkg.sv
// Shared types, defaults and address-decode helpers for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH   = 64;
  localparam int unsigned IMEM_LATENCY = 2;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } imem_rsp_t;

  // Word index of a byte address; caller truncates to the array index width.
  function automatic logic [31:0] imem_word_idx(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) & (depth - 32'd1);
  endfunction

  // Misaligned, or beyond the last word (compared in words to avoid 4*depth overflow).
  function automatic logic imem_addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus program loader port.
interface imem_responder_if import imem_pkg::*; #(
  parameter int unsigned DEPTH = IMEM_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_err;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [WORD_W-1:0] load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x 32 program storage: one synchronous write port, one combinational read port.
module imem_array import imem_pkg::*; #(
  parameter  int unsigned DEPTH = IMEM_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed LATENCY and back-pressure.
module imem_responder import imem_pkg::*; #(
  parameter int unsigned DEPTH   = IMEM_DEPTH,
  parameter int unsigned LATENCY = IMEM_LATENCY
) (
  input logic            clk,
  input logic            reset,
  imem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  imem_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  imem_rsp_t         rsp_q, rsp_d;
  logic              req_ready_c;
  logic              accept_c;
  logic [AW-1:0]     ridx;
  logic [WORD_W-1:0] rdata;

  assign ridx = AW'(imem_word_idx(bus.req_addr, DEPTH));

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (bus.load_en),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (ridx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept_c) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == CW'(LATENCY - 1)) state_d = RESP;
      RESP: begin
        if (accept_c)           state_d = (LATENCY == 1) ? RESP : WAIT;
        else if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The array is sampled at accept so later loads cannot disturb an in-flight response.
  always_comb begin
    req_ready_c = reset && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    accept_c    = bus.req_valid && req_ready_c;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    if (accept_c) begin
      cnt_d      = CW'(1);
      rsp_d.err  = imem_addr_err(bus.req_addr, DEPTH);
      rsp_d.data = rsp_d.err ? '0 : rdata;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed plus randomized bench for imem_responder at LATENCY 2 and LATENCY 1.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          LAT [2] = '{2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid_t [2];
  logic [31:0]       req_addr_t  [2];
  logic              rsp_ready_t [2];
  logic              load_en_t;
  logic [AW-1:0]     load_addr_t;
  logic [31:0]       load_data_t;
  logic              req_ready_w [2];
  logic              rsp_valid_w [2];
  logic [31:0]       rsp_data_w  [2];
  logic              rsp_err_w   [2];

  imem_responder_if #(.DEPTH(DEPTH)) bus_l2 ();
  imem_responder_if #(.DEPTH(DEPTH)) bus_l1 ();

  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_l2 (.clk(clk), .reset(rst_n), .bus(bus_l2.slave));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (.clk(clk), .reset(rst_n), .bus(bus_l1.slave));

  assign bus_l2.req_valid = req_valid_t[0];
  assign bus_l2.req_addr  = req_addr_t[0];
  assign bus_l2.rsp_ready = rsp_ready_t[0];
  assign bus_l2.load_en   = load_en_t;
  assign bus_l2.load_addr = load_addr_t;
  assign bus_l2.load_data = load_data_t;
  assign bus_l1.req_valid = req_valid_t[1];
  assign bus_l1.req_addr  = req_addr_t[1];
  assign bus_l1.rsp_ready = rsp_ready_t[1];
  assign bus_l1.load_en   = load_en_t;
  assign bus_l1.load_addr = load_addr_t;
  assign bus_l1.load_data = load_data_t;

  assign req_ready_w[0] = bus_l2.req_ready;
  assign rsp_valid_w[0] = bus_l2.rsp_valid;
  assign rsp_data_w[0]  = bus_l2.rsp_data;
  assign rsp_err_w[0]   = bus_l2.rsp_err;
  assign req_ready_w[1] = bus_l1.req_ready;
  assign rsp_valid_w[1] = bus_l1.rsp_valid;
  assign rsp_data_w[1]  = bus_l1.rsp_data;
  assign rsp_err_w[1]   = bus_l1.rsp_err;

  // Reference: program image plus the one pending response and the cycle it becomes visible.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic [31:0] mem_m [DEPTH];
  exp_t        q [$];
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_of(input logic [31:0] a, input int due);
    exp_t e;
    e.err  = ((a % 4) != 0) || (a >= 4 * DEPTH);
    e.data = 32'h0;
    if (!e.err) e.data = mem_m[a / 4];
    e.due  = due;
    return e;
  endfunction

  // One clock of stimulus on DUT d; entered and left 1 time unit after a rising edge.
  task automatic cycle(input int d, input logic v, input logic [31:0] a, input logic rr,
                       input logic le, input logic [AW-1:0] li, input logic [31:0] ld,
                       output bit acc, output bit dlv, output logic [31:0] obs);
    bit    due_now, exp_ready;
    string p;
    p = $sformatf("L%0d", LAT[d]);
    req_valid_t[d] = v;  req_addr_t[d] = a;  rsp_ready_t[d] = rr;
    req_valid_t[1-d] = 1'b0;  rsp_ready_t[1-d] = 1'b1;
    load_en_t = le;  load_addr_t = li;  load_data_t = ld;
    #1;
    due_now   = (q.size() != 0) && (cyc >= q[0].due);
    exp_ready = (q.size() == 0) || (due_now && rr);
    check({p, " rsp_valid"}, 32'(rsp_valid_w[d]), 32'(due_now));
    check({p, " req_ready"}, 32'(req_ready_w[d]), 32'(exp_ready));
    if (due_now) begin
      check({p, " rsp_data"}, rsp_data_w[d], q[0].data);
      check({p, " rsp_err"}, 32'(rsp_err_w[d]), 32'(q[0].err));
    end
    obs = rsp_data_w[d];
    dlv = due_now && rr;
    acc = v && exp_ready;
    if (dlv) void'(q.pop_front());
    if (acc) q.push_back(expect_of(a, cyc + LAT[d]));
    if (le) mem_m[li] = ld;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Issue addrs back-to-back with rsp_ready high; checks spacing between delivered responses.
  task automatic stream(input int d, input logic [31:0] addrs [$], input int gap);
    int p = 0;
    int last = -1;
    int budget = 0;
    bit acc, dlv;
    logic [31:0] obs;
    while ((p < addrs.size() || q.size() != 0) && budget < 100) begin
      if (p < addrs.size()) cycle(d, 1'b1, addrs[p], 1'b1, 1'b0, '0, '0, acc, dlv, obs);
      else                  cycle(d, 1'b0, 32'h0,    1'b1, 1'b0, '0, '0, acc, dlv, obs);
      if (acc) p++;
      if (dlv) begin
        if (last >= 0) check($sformatf("L%0d response spacing", LAT[d]), 32'(cyc - 1 - last), 32'(gap));
        last = cyc - 1;
      end
      budget++;
    end
    check($sformatf("L%0d stream completes", LAT[d]), 32'(budget < 100), 32'd1);
  endtask

  initial begin
    bit          acc, dlv;
    logic [31:0] obs, a;
    logic [31:0] aq [$];
    int          n;

    n_checks = 0;  n_fail = 0;  cyc = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid_t[d] = 1'b0;  req_addr_t[d] = '0;  rsp_ready_t[d] = 1'b1;
    end
    load_en_t = 1'b0;  load_addr_t = '0;  load_data_t = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d reset rsp_valid", LAT[d]), 32'(rsp_valid_w[d]), 32'd0);
      check($sformatf("L%0d reset req_ready", LAT[d]), 32'(req_ready_w[d]), 32'd0);
      check($sformatf("L%0d reset rsp_data", LAT[d]), rsp_data_w[d], 32'd0);
      check($sformatf("L%0d reset rsp_err", LAT[d]), 32'(rsp_err_w[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("L%0d ready after reset", LAT[d]), 32'(req_ready_w[d]), 32'd1);
    @(posedge clk); #1;

    // Program image
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1'b0, 32'h0, 1'b1, 1'b1, AW'(i), $urandom, acc, dlv, obs);
    cycle(0, 1'b0, 32'h0, 1'b1, 1'b1, AW'(0), 32'h11111111, acc, dlv, obs);
    cycle(0, 1'b0, 32'h0, 1'b1, 1'b1, AW'(1), 32'h22222222, acc, dlv, obs);
    cycle(0, 1'b0, 32'h0, 1'b1, 1'b1, AW'(2), 32'h33333333, acc, dlv, obs);
    cycle(0, 1'b0, 32'h0, 1'b1, 1'b1, AW'(3), 32'h44444444, acc, dlv, obs);

    // Sequential fetch, latency 2 and latency 1
    aq = '{32'h0, 32'h4, 32'h8, 32'hC};
    stream(0, aq, 2);
    aq = '{32'h0, 32'h4, 32'h8};
    stream(1, aq, 1);

    // Misaligned and out-of-range
    aq = '{32'h6, 32'h100};
    stream(0, aq, 2);
    aq = '{32'h6, 32'h100, 32'h4};
    stream(1, aq, 1);

    // Back-pressure: hold the 0x4 response for 5 cycles with 0x8 waiting
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      cycle(0, 1'b1, 32'h4, 1'b0, 1'b0, '0, '0, acc, dlv, obs);
      n++;
    end
    cycle(0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0, acc, dlv, obs);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0, acc, dlv, obs);
      check("held rsp_data", obs, 32'h22222222);
    end
    cycle(0, 1'b1, 32'h8, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
    check("released rsp_data", obs, 32'h22222222);
    aq = {};
    stream(0, aq, 2);

    // Load and fetch of the same word in one cycle returns the old word
    cycle(0, 1'b1, 32'h8, 1'b1, 1'b1, AW'(2), 32'hDEADBEEF, acc, dlv, obs);
    n = 0;
    dlv = 1'b0;
    while (!dlv && n < 10) begin
      cycle(0, 1'b0, 32'h0, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
      n++;
    end
    check("read-before-write data", obs, 32'h33333333);
    cycle(0, 1'b1, 32'h8, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
    n = 0;
    dlv = 1'b0;
    while (!dlv && n < 10) begin
      cycle(0, 1'b0, 32'h0, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
      n++;
    end
    check("post-load data", obs, 32'hDEADBEEF);

    // Reset while a request waits
    cycle(0, 1'b1, 32'h4, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
    req_valid_t[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset in WAIT rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("reset in WAIT req_ready", 32'(req_ready_w[0]), 32'd0);
    check("reset in WAIT rsp_data", rsp_data_w[0], 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready after mid reset", 32'(req_ready_w[0]), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cycle(0, 1'b0, 32'h0, 1'b1, 1'b0, '0, '0, acc, dlv, obs);
    aq = '{32'h0};
    stream(0, aq, 2);
    check("array kept over reset", mem_m[0], 32'h11111111);

    // Randomized traffic with loads and back-pressure
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 300; k++) begin
        case ($urandom_range(0, 7))
          0:       a = $urandom;
          1:       a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
          default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
        cycle(d, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 5) == 0), AW'($urandom_range(0, DEPTH - 1)), $urandom,
              acc, dlv, obs);
      end
      aq = {};
      stream(d, aq, LAT[d]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
